// File: rtl/regfile_wr_arbiter_if.sv
// Bundles the core writeback, long-latency unit, read-hazard and register-file write
// signals of regfile_wr_arbiter; master drives requests, slave is the arbiter.
interface regfile_wr_arbiter_if #(
  parameter int XLEN = 64,
  parameter int AW   = 5
);
  logic            core_we;
  logic [AW-1:0]   core_waddr;
  logic [XLEN-1:0] core_wdata;
  logic            lu_valid;
  logic            lu_ready;
  logic [AW-1:0]   lu_waddr;
  logic [XLEN-1:0] lu_wdata;
  logic [AW-1:0]   rd_addr_1;
  logic [AW-1:0]   rd_addr_2;
  logic            hazard_1;
  logic            hazard_2;
  logic            rf_we;
  logic [AW-1:0]   rf_waddr;
  logic [XLEN-1:0] rf_wdata;
  logic            core_stall;
  logic [AW-1:0]   fifo_count;

  modport master (
    output core_we, core_waddr, core_wdata,
    output lu_valid, lu_waddr, lu_wdata,
    output rd_addr_1, rd_addr_2,
    input  lu_ready, hazard_1, hazard_2,
    input  rf_we, rf_waddr, rf_wdata, core_stall, fifo_count
  );

  modport slave (
    input  core_we, core_waddr, core_wdata,
    input  lu_valid, lu_waddr, lu_wdata,
    input  rd_addr_1, rd_addr_2,
    output lu_ready, hazard_1, hazard_2,
    output rf_we, rf_waddr, rf_wdata, core_stall, fifo_count
  );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// Register-file write-port arbiter: core writeback has priority, long-latency results are
// buffered in a FIFO and drained in idle slots. Define REGFILE_ARB_STARVE_EN for core stalls.
module regfile_wr_arbiter #(
  parameter int XLEN         = 64,
  parameter int AW           = 5,
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input logic                  clk,
  input logic                  rst,
  regfile_wr_arbiter_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || STARVE_LIMIT < 1) begin : g_bad_param
    $error("regfile_wr_arbiter: DEPTH must be a power of 2 >= 2 and STARVE_LIMIT >= 1");
  end

  logic [AW-1:0]   r_mem_addr [DEPTH];
  logic [XLEN-1:0] r_mem_data [DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [AW-1:0]   r_count;
  logic            r_rf_we;
  logic [AW-1:0]   r_rf_waddr;
  logic [XLEN-1:0] r_rf_wdata;

  logic            w_lu_ready;
  logic            w_push;
  logic            w_empty;
  logic            w_core_grant;
  logic            w_fifo_grant;
  logic            w_core_stall;
  logic [PW-1:0]   w_off [DEPTH];
  logic [DEPTH-1:0] w_valid;
  logic            w_hazard_1;
  logic            w_hazard_2;

  // No pop-through: a full FIFO refuses the unit even in a cycle that drains it.
  assign w_lu_ready   = r_count < AW'(DEPTH);
  assign w_push       = bus.lu_valid && w_lu_ready && (bus.lu_waddr != '0);
  assign w_empty      = (r_count == '0);
  assign w_core_grant = bus.core_we && (bus.core_waddr != '0) && !w_core_stall;
  assign w_fifo_grant = !w_core_grant && !w_empty;

  // NOTE: every variable gets a default before the loop so no latch is inferred.
  always_comb begin
    w_off      = '{default: '0};
    w_valid    = '0;
    w_hazard_1 = 1'b0;
    w_hazard_2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      w_off[i]   = PW'(i) - r_rd_ptr;
      w_valid[i] = AW'(w_off[i]) < r_count;
      if (w_valid[i] && r_mem_addr[i] == bus.rd_addr_1) w_hazard_1 = 1'b1;
      if (w_valid[i] && r_mem_addr[i] == bus.rd_addr_2) w_hazard_2 = 1'b1;
    end
    if (r_rf_we && r_rf_waddr == bus.rd_addr_1) w_hazard_1 = 1'b1;
    if (r_rf_we && r_rf_waddr == bus.rd_addr_2) w_hazard_2 = 1'b1;
    if (bus.rd_addr_1 == '0) w_hazard_1 = 1'b0;
    if (bus.rd_addr_2 == '0) w_hazard_2 = 1'b0;
  end

  // NOTE: FIFO storage has no reset; entries are only read when the pointers mark them valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_addr[r_wr_ptr] <= bus.lu_waddr;
      r_mem_data[r_wr_ptr] <= bus.lu_wdata;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_rf_we    <= 1'b0;
      r_rf_waddr <= '0;
      r_rf_wdata <= '0;
    end else begin
      if (w_push)       r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_fifo_grant) r_rd_ptr <= r_rd_ptr + PW'(1);
      if (w_push && !w_fifo_grant)      r_count <= r_count + AW'(1);
      else if (!w_push && w_fifo_grant) r_count <= r_count - AW'(1);

      r_rf_we <= w_core_grant || w_fifo_grant;
      if (w_core_grant) begin
        r_rf_waddr <= bus.core_waddr;
        r_rf_wdata <= bus.core_wdata;
      end else if (w_fifo_grant) begin
        r_rf_waddr <= r_mem_addr[r_rd_ptr];
        r_rf_wdata <= r_mem_data[r_rd_ptr];
      end
    end
  end

`ifdef REGFILE_ARB_STARVE_EN
  localparam int SCW = $clog2(STARVE_LIMIT + 1);

  logic [SCW-1:0] r_starve_cnt;
  logic           r_core_stall;
  logic           w_starving;

  assign w_starving   = !w_empty && !w_fifo_grant;
  assign w_core_stall = r_core_stall;

  // Stall asserts after STARVE_LIMIT consecutive ungranted cycles and holds until the head drains.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_starve_cnt <= '0;
      r_core_stall <= 1'b0;
    end else begin
      if (!w_starving)                             r_starve_cnt <= '0;
      else if (r_starve_cnt != SCW'(STARVE_LIMIT)) r_starve_cnt <= r_starve_cnt + SCW'(1);

      if (w_fifo_grant)                                           r_core_stall <= 1'b0;
      else if (w_starving && r_starve_cnt >= SCW'(STARVE_LIMIT - 1)) r_core_stall <= 1'b1;
    end
  end
`else
  assign w_core_stall = 1'b0;
`endif

  assign bus.lu_ready   = w_lu_ready;
  assign bus.hazard_1   = w_hazard_1;
  assign bus.hazard_2   = w_hazard_2;
  assign bus.rf_we      = r_rf_we;
  assign bus.rf_waddr   = r_rf_waddr;
  assign bus.rf_wdata   = r_rf_wdata;
  assign bus.core_stall = w_core_stall;
  assign bus.fifo_count = r_count;
endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Self-checking bench for regfile_wr_arbiter: per-cycle vector table, write-order
// scoreboard, starvation sequence and mid-operation reset.
module tb_regfile_wr_arbiter;
  localparam int XLEN         = 64;
  localparam int AW           = 5;
  localparam int DEPTH        = 2;
  localparam int STARVE_LIMIT = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_wr_arbiter_if #(.XLEN(XLEN), .AW(AW)) bus ();

  regfile_wr_arbiter #(
    .XLEN(XLEN), .AW(AW), .DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
  } wr_t;

  typedef struct {
    logic            cwe;
    logic [AW-1:0]   ca;
    logic [XLEN-1:0] cd;
    logic            lv;
    logic [AW-1:0]   la;
    logic [XLEN-1:0] ld;
    logic [AW-1:0]   r1;
    logic [AW-1:0]   r2;
    logic            e_rdy;
    logic            e_hz1;
    logic            e_hz2;
    logic [AW-1:0]   e_cnt;
    logic            e_we;
    logic [AW-1:0]   e_waddr;
  } vec_t;

  wr_t  exp_q [$];
  wr_t  m_q   [$];
  bit   sb_en;
  int   n_checks = 0;
  int   n_pass   = 0;
  vec_t vecs [19];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Drives one cycle of inputs and predicts the write granted at the coming edge.
  task automatic cycle(input logic cwe, input logic [AW-1:0] ca, input logic [XLEN-1:0] cd,
                       input logic lv, input logic [AW-1:0] la, input logic [XLEN-1:0] ld,
                       input logic [AW-1:0] r1, input logic [AW-1:0] r2);
    bit rdy;
    @(posedge clk);
    #1;
    bus.core_we = cwe; bus.core_waddr = ca; bus.core_wdata = cd;
    bus.lu_valid = lv; bus.lu_waddr = la; bus.lu_wdata = ld;
    bus.rd_addr_1 = r1; bus.rd_addr_2 = r2;
    rdy = m_q.size() < DEPTH;
    if (cwe && ca != '0)     exp_q.push_back(wr_t'{addr: ca, data: cd});
    else if (m_q.size() > 0) exp_q.push_back(m_q.pop_front());
    if (lv && rdy && la != '0) m_q.push_back(wr_t'{addr: la, data: ld});
    @(negedge clk);
  endtask

  task automatic idle(input logic [AW-1:0] r1, input logic [AW-1:0] r2);
    cycle(1'b0, '0, '0, 1'b0, '0, '0, r1, r2);
  endtask

  // Scoreboard: every register-file write must match the next predicted write.
  always @(negedge clk) begin
    wr_t w;
    if (sb_en && rst && bus.rf_we) begin
      if (exp_q.size() == 0) begin
        check("sb_spurious_rf_we", bus.rf_we, 1'b0);
      end else begin
        w = exp_q.pop_front();
        check("sb_waddr", bus.rf_waddr, w.addr);
        check("sb_wdata", bus.rf_wdata, w.data);
      end
    end
  end

  initial begin
    //          cwe ca  cd        lv la  ld         r1 r2  rdy hz1 hz2 cnt we waddr
    vecs[0]  = '{0, 0, 64'h0,    0, 0, 64'h0,    0, 0, 1, 0, 0, 0, 0, 0};
    vecs[1]  = '{1, 5, 64'hAA,   0, 0, 64'h0,    5, 0, 1, 0, 0, 0, 0, 0};
    vecs[2]  = '{0, 0, 64'h0,    0, 0, 64'h0,    5, 0, 1, 1, 0, 0, 1, 5};
    vecs[3]  = '{0, 0, 64'h0,    1, 7, 64'h55,   7, 0, 1, 0, 0, 0, 0, 5};
    vecs[4]  = '{0, 0, 64'h0,    0, 0, 64'h0,    7, 0, 1, 1, 0, 1, 0, 5};
    vecs[5]  = '{0, 0, 64'h0,    0, 0, 64'h0,    7, 7, 1, 1, 1, 0, 1, 7};
    vecs[6]  = '{0, 0, 64'h0,    0, 0, 64'h0,    7, 0, 1, 0, 0, 0, 0, 7};
    vecs[7]  = '{1, 1, 64'h11,   1, 2, 64'h22,   2, 0, 1, 0, 0, 0, 0, 7};
    vecs[8]  = '{1, 3, 64'h33,   1, 4, 64'h44,   2, 4, 1, 1, 0, 1, 1, 1};
    vecs[9]  = '{1, 6, 64'h66,   1, 8, 64'h88,   2, 4, 0, 1, 1, 2, 1, 3};
    vecs[10] = '{0, 0, 64'h0,    1, 8, 64'h88,   8, 0, 0, 0, 0, 2, 1, 6};
    vecs[11] = '{0, 0, 64'h0,    1, 8, 64'h88,   8, 4, 1, 0, 1, 1, 1, 2};
    vecs[12] = '{0, 0, 64'h0,    0, 0, 64'h0,    8, 4, 1, 1, 1, 1, 1, 4};
    vecs[13] = '{0, 0, 64'h0,    0, 0, 64'h0,    8, 0, 1, 1, 0, 0, 1, 8};
    vecs[14] = '{1, 0, 64'hDEAD, 1, 0, 64'hBEEF, 0, 8, 1, 0, 0, 0, 0, 8};
    vecs[15] = '{1, 0, 64'hDEAD, 1, 9, 64'h99,   9, 0, 1, 0, 0, 0, 0, 8};
    vecs[16] = '{1, 0, 64'hDEAD, 0, 0, 64'h0,    9, 0, 1, 1, 0, 1, 0, 8};
    vecs[17] = '{0, 0, 64'h0,    0, 0, 64'h0,    9, 0, 1, 1, 0, 0, 1, 9};
    vecs[18] = '{0, 0, 64'h0,    0, 0, 64'h0,    9, 0, 1, 0, 0, 0, 0, 9};

    sb_en = 1'b1;
    rst = 1'b0;
    bus.core_we = 1'b0; bus.core_waddr = '0; bus.core_wdata = '0;
    bus.lu_valid = 1'b0; bus.lu_waddr = '0; bus.lu_wdata = '0;
    bus.rd_addr_1 = '0; bus.rd_addr_2 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    check("rst_rf_we",      bus.rf_we, 1'b0);
    check("rst_rf_waddr",   bus.rf_waddr, '0);
    check("rst_rf_wdata",   bus.rf_wdata, '0);
    check("rst_lu_ready",   bus.lu_ready, 1'b1);
    check("rst_fifo_count", bus.fifo_count, '0);
    check("rst_core_stall", bus.core_stall, 1'b0);
    check("rst_hazard_1",   bus.hazard_1, 1'b0);
    check("rst_hazard_2",   bus.hazard_2, 1'b0);

    for (int i = 0; i < 19; i++) begin
      cycle(vecs[i].cwe, vecs[i].ca, vecs[i].cd, vecs[i].lv, vecs[i].la, vecs[i].ld,
            vecs[i].r1, vecs[i].r2);
      check($sformatf("v%0d_lu_ready", i),   bus.lu_ready,   vecs[i].e_rdy);
      check($sformatf("v%0d_hazard_1", i),   bus.hazard_1,   vecs[i].e_hz1);
      check($sformatf("v%0d_hazard_2", i),   bus.hazard_2,   vecs[i].e_hz2);
      check($sformatf("v%0d_fifo_count", i), bus.fifo_count, vecs[i].e_cnt);
      check($sformatf("v%0d_rf_we", i),      bus.rf_we,      vecs[i].e_we);
      check($sformatf("v%0d_rf_waddr", i),   bus.rf_waddr,   vecs[i].e_waddr);
    end

    // Core requests every cycle while one unit result waits in the FIFO.
`ifdef REGFILE_ARB_STARVE_EN
    sb_en = 1'b0;
    cycle(1'b1, 5'd10, 64'hA0, 1'b1, 5'd11, 64'hB0, 5'd11, 5'd0);
    for (int k = 1; k <= 7; k++) begin
      cycle(1'b1, 5'd10, 64'hA0, 1'b0, '0, '0, 5'd11, 5'd0);
      check($sformatf("starve_k%0d_core_stall", k), bus.core_stall, (k == 5));
      check($sformatf("starve_k%0d_rf_we", k),      bus.rf_we, 1'b1);
      check($sformatf("starve_k%0d_rf_waddr", k),   bus.rf_waddr, (k == 6) ? 5'd11 : 5'd10);
      check($sformatf("starve_k%0d_fifo_count", k), bus.fifo_count, (k <= 5) ? 5'd1 : 5'd0);
    end
    check("starve_lu_wdata_seen", 1'b1, 1'b1 & (bus.rf_wdata == 64'hA0));
    idle('0, '0);
    idle('0, '0);
    exp_q.delete();
    m_q.delete();
    sb_en = 1'b1;
`else
    cycle(1'b1, 5'd10, 64'hA0, 1'b1, 5'd11, 64'hB0, 5'd11, 5'd0);
    for (int k = 1; k <= 7; k++) begin
      cycle(1'b1, 5'd10, 64'hA0, 1'b0, '0, '0, 5'd11, 5'd0);
      check($sformatf("nostarve_k%0d_core_stall", k), bus.core_stall, 1'b0);
      check($sformatf("nostarve_k%0d_fifo_count", k), bus.fifo_count, 5'd1);
      check($sformatf("nostarve_k%0d_hazard_1", k),   bus.hazard_1, 1'b1);
    end
    idle(5'd11, 5'd0);
    idle(5'd11, 5'd0);
    check("nostarve_drain_rf_waddr", bus.rf_waddr, 5'd11);
    check("nostarve_drain_rf_wdata", bus.rf_wdata, 64'hB0);
    check("nostarve_drain_count",    bus.fifo_count, 5'd0);
    idle('0, '0);
`endif

    // Fill the FIFO behind a busy core, then reset with both entries buffered.
    cycle(1'b1, 5'd12, 64'hC0, 1'b1, 5'd13, 64'hD0, 5'd13, 5'd15);
    cycle(1'b1, 5'd14, 64'hE0, 1'b1, 5'd15, 64'hF0, 5'd13, 5'd15);
    @(posedge clk);
    #1;
    check("pre_reset_fifo_count", bus.fifo_count, 5'd2);
    check("pre_reset_lu_ready",   bus.lu_ready, 1'b0);
    rst = 1'b0;
    exp_q.delete();
    m_q.delete();
    #1;
    check("mid_reset_fifo_count", bus.fifo_count, 5'd0);
    check("mid_reset_rf_we",      bus.rf_we, 1'b0);
    check("mid_reset_lu_ready",   bus.lu_ready, 1'b1);
    bus.core_we = 1'b0; bus.lu_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      idle(5'd13, 5'd15);
      check($sformatf("post_reset_k%0d_rf_we", k),      bus.rf_we, 1'b0);
      check($sformatf("post_reset_k%0d_fifo_count", k), bus.fifo_count, 5'd0);
      check($sformatf("post_reset_k%0d_hazard_1", k),   bus.hazard_1, 1'b0);
      check($sformatf("post_reset_k%0d_hazard_2", k),   bus.hazard_2, 1'b0);
    end

    check("sb_all_writes_seen", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
